pmc_uart_reporter: RTL and testbench
====================================

Name: pmc_uart_reporter

Overview:
- Downstream consumer of the performance-monitor counter unit's four 256-bit metric buses.
- On a single-cycle request, snapshots the meaningful low bits of each metric and packs them into a fixed 16-byte frame with sync byte and XOR checksum.
- Transmits the frame over an 8N1 UART TX line so host tooling can read stall, arithmetic, memory-access and CPI (Q7.8) figures without halting the processor.

Parameters:
- CLK_FREQ_HZ, 50000000, core clock frequency.
- BAUD_RATE, 115200, UART bit rate.
- CLKS_PER_BIT, CLK_FREQ_HZ/BAUD_RATE (434), cycles per UART bit. Elaboration error if < 2.
- SYNC_BYTE, 8'hA5, first byte of every frame.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-low reset
- report_req  in  1  request pulse; accepted only while idle
- stall_count_in  in  256  stall count; bits [31:0] used
- cpi_q78_in  in  256  CPI in Q7.8; bits [15:0] used
- arith_count_in  in  256  arithmetic count; bits [31:0] used
- mem_access_count_in  in  256  memory-access count; bits [31:0] used
- tx  out  1  UART serial output, idle high
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse at frame completion
- frame_count  out  16  completed frames, wraps

Behaviour:
- Reset (reset=0, asynchronous):
  - tx=1, busy=0, done=0, frame_count=0, FSM=IDLE.
  - Snapshot, byte index and bit counters cleared.
  - Reset mid-frame abandons the frame and forces tx high immediately; no partial completion is counted.
- Frame layout, 16 bytes:
  - byte 0: SYNC_BYTE
  - bytes 1-4: stall[31:0], MSB first
  - bytes 5-8: arith[31:0], MSB first
  - bytes 9-12: mem_access[31:0], MSB first
  - bytes 13-14: cpi[15:0], MSB first
  - byte 15: XOR of bytes 1-14
  - Upper input bits are ignored.
- Request acceptance:
  - report_req sampled on every clk edge while FSM=IDLE.
  - The accepting edge captures all four inputs into a snapshot register, sets busy=1 and enters START with byte index 0.
  - Inputs may change freely afterwards.
  - report_req while busy is ignored; it is not queued.
- FSM states: IDLE -> START -> DATA -> STOP -> (next byte START | IDLE).
  - START drives tx=0 for CLKS_PER_BIT cycles.
  - DATA drives 8 bits LSB first, CLKS_PER_BIT cycles each.
  - STOP drives tx=1 for CLKS_PER_BIT cycles.
  - After STOP of byte 15: FSM=IDLE, busy=0, done=1 for one cycle, frame_count+1 (0xFFFF -> 0x0000).
- Timing:
  - tx falls on the first cycle after the accepting edge.
  - Frame length is exactly 160*CLKS_PER_BIT cycles.
  - done rises on the first cycle after that, with no gap between bytes.
- Back-to-back: a report_req high in the same cycle done=1 (FSM already IDLE) is accepted; the next start bit follows with zero idle bit-time.
- Checksum is computed from the snapshot, either incrementally per byte or combinationally. Byte 15 must reflect snapshot values only.
- Bit timing: a down-counter reloads CLKS_PER_BIT-1; bit and byte indices advance only at counter zero.

Decomposition:
- Package pmc_report_pkg holds:
  - the FSM state enum (IDLE, START, DATA, STOP)
  - FRAME_BYTES=16 and SYNC_BYTE default
  - byte-offset constants for each field
- Sub-module uart_tx_byte: 8N1 serializer with a start/ready handshake and CLKS_PER_BIT parameter, owning the START/DATA/STOP states.
- The top level owns snapshot capture, byte mux, checksum, frame sequencing and frame_count.

Test Plan (CLK_FREQ_HZ=1000, BAUD_RATE=250 -> CLKS_PER_BIT=4; frame = 640 cycles):
- Basic frame:
  - Stimulus: stall=0x12, arith=0x345, mem=0x6789, cpi=0x0280, one report_req pulse.
  - Required: decoded bytes A5 00 00 00 12 00 00 03 45 00 00 67 89 02 80 38; done 640 cycles after tx falls; frame_count=1.
- Snapshot isolation: change all inputs to 0xFFFFFFFF one cycle after acceptance -> frame identical to the basic case.
- Upper-bit masking: stall_count_in[255:32] all ones, [31:0]=0 -> stall bytes 00 00 00 00; checksum ignores upper bits.
- Request while busy: pulse report_req at cycle 100 of a frame -> ignored; exactly one frame, frame_count increments by 1.
- Back-to-back: hold report_req high across done -> second frame's start bit immediately follows the first frame's last stop bit; frame_count=2.
- Reset mid-frame: assert reset at cycle 300 -> tx=1 and busy=0 asynchronously, frame_count=0; a fresh request after release yields a complete, correct frame.

Source files
------------

// File: rtl/pmc_report_pkg.sv
// pmc_report_pkg: shared types and frame layout constants for the PMC UART reporter
// Contents: serializer state enum, frame size, default sync byte, field byte offsets,
//           and a byte-wise XOR helper for the frame checksum.
package pmc_report_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;

    localparam int FRAME_BYTES = 16;
    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    localparam int STALL_OFS = 1;
    localparam int ARITH_OFS = 5;
    localparam int MEM_OFS   = 9;
    localparam int CPI_OFS   = 13;
    localparam int CHK_OFS   = 15;

    function automatic logic [7:0] xor_bytes32(input logic [31:0] v);
        return v[31:24] ^ v[23:16] ^ v[15:8] ^ v[7:0];
    endfunction

endpackage

// File: rtl/pmc_uart_reporter_if.sv
// pmc_uart_reporter_if: request/metric/status bundle between a host-side driver and the reporter
// Signals: report_req, four 256-bit metric buses (in to reporter);
//          tx, busy, done, frame_count (out of reporter).
interface pmc_uart_reporter_if;
    logic         report_req;
    logic [255:0] stall_count_in;
    logic [255:0] cpi_q78_in;
    logic [255:0] arith_count_in;
    logic [255:0] mem_access_count_in;
    logic         tx;
    logic         busy;
    logic         done;
    logic [15:0]  frame_count;

    modport master (
        output report_req, stall_count_in, cpi_q78_in, arith_count_in, mem_access_count_in,
        input  tx, busy, done, frame_count
    );

    modport slave (
        input  report_req, stall_count_in, cpi_q78_in, arith_count_in, mem_access_count_in,
        output tx, busy, done, frame_count
    );
endinterface

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 serializer, LSB first, CLKS_PER_BIT cycles per bit
// Ports: clk, reset (async active-low), start/data (byte offered), ready (start is taken
//        this cycle when high), tx (registered serial line, idle high).
module uart_tx_byte
    import pmc_report_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       ready,
    output logic       tx
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_rate
        $error("CLKS_PER_BIT must be >= 2");
    end

    tx_state_e     state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    sh;
    logic          tick;

    assign tick  = cnt == '0;
    // Ready on the last stop-bit cycle too, so the next byte starts with no gap.
    assign ready = state == IDLE || (state == STOP && tick);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            sh      <= '0;
            tx      <= 1'b1;
        end else if (ready && start) begin
            state <= START;
            cnt   <= RELOAD;
            sh    <= data;
            tx    <= 1'b0;
        end else if (state != IDLE) begin
            if (!tick) begin
                cnt <= cnt - CW'(1);
            end else begin
                cnt <= RELOAD;
                unique case (state)
                    START: begin
                        state   <= DATA;
                        bit_idx <= '0;
                        tx      <= sh[0];
                        sh      <= sh >> 1;
                    end
                    DATA: begin
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= sh[0];
                            sh      <= sh >> 1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: rtl/pmc_uart_reporter.sv
// pmc_uart_reporter: snapshots PMC metrics on request and sends a 16-byte checksummed frame over UART
// Ports: clk, reset (async active-low), bus (slave side of pmc_uart_reporter_if:
//        report_req + metric buses in; tx, busy, done pulse, frame_count out).
module pmc_uart_reporter
    import pmc_report_pkg::*;
#(
    parameter int         CLK_FREQ_HZ = 50000000,
    parameter int         BAUD_RATE   = 115200,
    parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF
) (
    input  logic                clk,
    input  logic                reset,
    pmc_uart_reporter_if.slave  bus
);
    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;

    logic [31:0] stall_q, arith_q, mem_q;
    logic [15:0] cpi_q;
    logic        busy_q, done_q;
    logic [15:0] fc_q;
    logic [3:0]  idx;
    logic        ready, start, accept, last;
    logic [7:0]  frame [FRAME_BYTES];
    logic [7:0]  tx_data;
    logic        unused_upper;

    assign unused_upper = ^{bus.stall_count_in[255:32], bus.arith_count_in[255:32],
                            bus.mem_access_count_in[255:32], bus.cpi_q78_in[255:16]};

    always_comb begin
        frame[0] = SYNC_BYTE;
        for (int i = 0; i < 4; i++) begin
            frame[STALL_OFS + i] = stall_q[31 - 8*i -: 8];
            frame[ARITH_OFS + i] = arith_q[31 - 8*i -: 8];
            frame[MEM_OFS + i]   = mem_q[31 - 8*i -: 8];
        end
        frame[CPI_OFS]     = cpi_q[15:8];
        frame[CPI_OFS + 1] = cpi_q[7:0];
        frame[CHK_OFS]     = xor_bytes32(stall_q) ^ xor_bytes32(arith_q) ^ xor_bytes32(mem_q)
                           ^ cpi_q[15:8] ^ cpi_q[7:0];
    end

    assign accept  = !busy_q && bus.report_req;
    assign last    = idx == 4'(FRAME_BYTES - 1);
    // The first byte is the constant sync byte, so it can be offered on the accepting edge
    // before the snapshot registers have loaded.
    assign start   = accept || (busy_q && ready && !last);
    assign tx_data = busy_q ? frame[idx + 4'd1] : SYNC_BYTE;

    uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .data  (tx_data),
        .ready (ready),
        .tx    (bus.tx)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
            arith_q <= '0;
            mem_q   <= '0;
            cpi_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fc_q    <= '0;
            idx     <= '0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                stall_q <= bus.stall_count_in[31:0];
                arith_q <= bus.arith_count_in[31:0];
                mem_q   <= bus.mem_access_count_in[31:0];
                cpi_q   <= bus.cpi_q78_in[15:0];
                busy_q  <= 1'b1;
                idx     <= '0;
            end else if (busy_q && ready) begin
                if (last) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                    fc_q   <= fc_q + 16'd1;
                end else begin
                    idx <= idx + 4'd1;
                end
            end
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.frame_count = fc_q;
endmodule

// File: tb/tb_pmc_uart_reporter.sv
// tb_pmc_uart_reporter: directed self-checking bench decoding the UART frame at 4 clocks per bit
module tb_pmc_uart_reporter;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    pmc_uart_reporter_if bus();

    pmc_uart_reporter #(.CLK_FREQ_HZ(1000), .BAUD_RATE(250)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    localparam logic [127:0] EXP_BASIC = 128'hA5_00000012_00000345_00006789_0280_38;
    localparam logic [127:0] EXP_MASK  = 128'hA5_00000000_00000345_00006789_0280_2A;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_in(input logic [255:0] s, input logic [255:0] a,
                          input logic [255:0] m, input logic [255:0] c);
        bus.stall_count_in      = s;
        bus.arith_count_in      = a;
        bus.mem_access_count_in = m;
        bus.cpi_q78_in          = c;
    endtask

    task automatic set_basic();
        set_in(256'h12, 256'h345, 256'h6789, 256'h0280);
    endtask

    task automatic pulse_req();
        @(negedge clk);
        bus.report_req = 1'b1;
        @(negedge clk);
        bus.report_req = 1'b0;
    endtask

    // Decodes one frame, sampling each bit mid-period on negedges; must be called no later
    // than the negedge on which the first start bit is visible.
    task automatic get_frame(input string tag, output logic [127:0] fr, output int fall);
        int w;
        int t15;
        bit stop_ok;
        fr = '0;
        fall = 0;
        t15 = 0;
        stop_ok = 1'b1;
        for (int b = 0; b < 16; b++) begin
            w = 0;
            while (bus.tx !== 1'b0 && w < 2000) begin
                @(negedge clk);
                w++;
            end
            if (bus.tx !== 1'b0) begin
                check({tag, "_start_timeout"}, 0, 1);
                return;
            end
            if (b == 0) fall = cyc;
            if (b == 15) t15 = cyc;
            for (int k = 0; k < 8; k++) begin
                repeat (k == 0 ? 6 : 4) @(negedge clk);
                fr[120 - 8*b + k] = bus.tx;
            end
            repeat (4) @(negedge clk);
            if (bus.tx !== 1'b1) stop_ok = 1'b0;
        end
        check({tag, "_stop_bits"}, stop_ok, 1);
        check({tag, "_byte_gap"}, t15 - fall, 600);
        w = 0;
        while (bus.done !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        check({tag, "_done_latency"}, cyc - fall, 640);
    endtask

    logic [127:0] fr, fr2;
    int fall, fall2;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.report_req = 1'b0;
        set_in('0, '0, '0, '0);
        repeat (3) @(negedge clk);
        check("rst_tx", bus.tx, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_fc", bus.frame_count, 0);
        reset = 1'b1;

        // basic frame
        set_basic();
        pulse_req();
        check("basic_busy", bus.busy, 1);
        get_frame("basic", fr, fall);
        check("basic_bytes", fr, EXP_BASIC);
        check("basic_fc", bus.frame_count, 1);
        @(negedge clk);
        check("basic_done_pulse", bus.done, 0);
        check("basic_idle_busy", bus.busy, 0);

        // snapshot isolation
        set_basic();
        pulse_req();
        set_in('1, '1, '1, '1);
        get_frame("snap", fr, fall);
        check("snap_bytes", fr, EXP_BASIC);
        check("snap_fc", bus.frame_count, 2);

        // upper-bit masking
        set_in({{224{1'b1}}, 32'h0}, 256'h345, 256'h6789, 256'h0280);
        pulse_req();
        get_frame("mask", fr, fall);
        check("mask_bytes", fr, EXP_MASK);
        check("mask_fc", bus.frame_count, 3);

        // request while busy is dropped
        set_basic();
        pulse_req();
        fork
            get_frame("busyreq", fr, fall);
            begin
                repeat (100) @(negedge clk);
                bus.report_req = 1'b1;
                @(negedge clk);
                bus.report_req = 1'b0;
            end
        join
        check("busyreq_bytes", fr, EXP_BASIC);
        check("busyreq_fc", bus.frame_count, 4);
        repeat (60) @(negedge clk);
        check("busyreq_no_second", {bus.busy, bus.tx}, 2'b01);
        check("busyreq_fc_after", bus.frame_count, 4);

        // back-to-back with report_req held across done
        @(negedge clk);
        bus.report_req = 1'b1;
        @(negedge clk);
        get_frame("b2b1", fr, fall);
        fork
            get_frame("b2b2", fr2, fall2);
            begin
                @(negedge clk);
                bus.report_req = 1'b0;
            end
        join
        check("b2b1_bytes", fr, EXP_BASIC);
        check("b2b2_bytes", fr2, EXP_BASIC);
        check("b2b_spacing", fall2 - fall, 641);
        check("b2b_fc", bus.frame_count, 6);

        // reset mid-frame
        pulse_req();
        repeat (300) @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_tx", bus.tx, 1);
        check("midrst_busy", bus.busy, 0);
        check("midrst_fc", bus.frame_count, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        check("midrst_idle_tx", bus.tx, 1);
        pulse_req();
        get_frame("postrst", fr, fall);
        check("postrst_bytes", fr, EXP_BASIC);
        check("postrst_fc", bus.frame_count, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
